// File: rtl/reset_sequencer.sv
// Staged reset release: holds bus and core in reset after reset_n deasserts,
// releases the bus domain first and the core a fixed gap later, and services
// debug-module reset requests with a four-phase req/ack handshake.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic ndm_req,
    output logic ndm_ack,
    output logic bus_reset,
    output logic core_reset,
    output logic ready
);

    localparam int MAX_COUNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int COUNT_W   = $clog2(MAX_COUNT + 1);
    localparam logic [COUNT_W-1:0] HOLD_LAST = COUNT_W'(HOLD_CYCLES - 1);
    localparam logic [COUNT_W-1:0] GAP_LAST  = COUNT_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        HOLD,
        BUS_UP,
        RUN,
        CORE_DN,
        ACKED
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [COUNT_W-1:0]   count;
    logic [COUNT_W-1:0]   count_next;
    logic                 bus_next;
    logic                 core_next;
    logic                 ready_next;
    logic                 ack_next;

    // State, counter and all outputs are registered so outputs never glitch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HOLD;
            count      <= '0;
            bus_reset  <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            ndm_ack    <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            bus_reset  <= bus_next;
            core_reset <= core_next;
            ready      <= ready_next;
            ndm_ack    <= ack_next;
        end
    end

    // Next-state and next-output logic; every value holds unless a transition changes it
    always_comb begin
        state_next = state;
        count_next = count;
        bus_next   = bus_reset;
        core_next  = core_reset;
        ready_next = ready;
        ack_next   = ndm_ack;
        case (state)
            HOLD: begin
                if (count == HOLD_LAST) begin
                    state_next = BUS_UP;
                    bus_next   = 1'b0;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            BUS_UP: begin
                if (count == GAP_LAST) begin
                    state_next = RUN;
                    core_next  = 1'b0;
                    ready_next = 1'b1;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            RUN: begin
                if (ndm_req) begin
                    state_next = CORE_DN;
                    core_next  = 1'b1;
                    ready_next = 1'b0;
                end
            end
            CORE_DN: begin
                state_next = ACKED;
                bus_next   = 1'b1;
                ack_next   = 1'b1;
            end
            ACKED: begin
                if (!ndm_req) begin
                    state_next = HOLD;
                    ack_next   = 1'b0;
                    count_next = '0;
                end
            end
            default: begin
                state_next = HOLD;
                count_next = '0;
                bus_next   = 1'b1;
                core_next  = 1'b1;
                ready_next = 1'b0;
                ack_next   = 1'b0;
            end
        endcase
    end

endmodule
